hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard/scheduling controller for the 5-stage pipeline: drives stall of the IF/ID registers and flush (bubble insert) of the ID/EX register.
//  Generates EX- and ID-stage forwarding selects.
//  Sequences the shared multi-cycle mult/div unit (MDU) with a busy FSM, stalling issue/use while the MDU runs.
// PARAMETERS
//  MULT_LAT  5   MDU cycles for mult/multu (>=1)
//  DIV_LAT   10  MDU cycles for div/divu (>=1, <=2**CNT_W)
//  CNT_W     4   MDU down-counter width
// PORTS
//  Clk        in   1  clock, rising edge
//  Reset_n    in   1  synchronous reset, active low
//  RsD,RtD    in   5  source regs of instr in ID
//  BranchD    in   1  ID instr is beq/bne (compared in ID)
//  MdStartD   in   1  ID instr is mult/multu/div/divu
//  MdIsDivD   in   1  with MdStartD: 1=div, 0=mult
//  MdUseD     in   1  ID instr is mfhi/mflo/mthi/mtlo
//  RsE,RtE    in   5  source regs in EX
//  WriteRegE  in   5  dest reg in EX;  RegWriteE, MemtoRegE in 1
//  WriteRegM  in   5  dest reg in MEM; RegWriteM, MemtoRegM in 1
//  WriteRegW  in   5  dest reg in WB;  RegWriteW in 1
//  StallF     out  1  hold PC
//  StallD     out  1  hold IF/ID
//  FlushE     out  1  load bubble (all-zero ctrl) into ID/EX
//  ForwardAE  out  2  EX srcA: 00 regfile, 01 WB result, 10 MEM ALU result
//  ForwardBE  out  2  EX srcB, same encoding
//  ForwardAD  out  1  ID branch cmp srcA from MEM ALU result
//  ForwardBD  out  1  ID branch cmp srcB from MEM ALU result
//  MdIssue    out  1  MDU start strobe, 1 cycle
//  MdBusy     out  1  MDU running
// BEHAVIOUR
//  Register $0 never matches any hazard/forward term (WriteReg*==0 ignored).
//  lwstall = RegWriteE & MemtoRegE & (WriteRegE==RsD | WriteRegE==RtD).
//  brstall = BranchD & ((RegWriteE & WriteRegE in {RsD,RtD}) | (MemtoRegM & WriteRegM in {RsD,RtD})).
//  mdstall = MdBusy & (MdStartD | MdUseD).
//  stall = lwstall|brstall|mdstall; StallF=StallD=FlushE=stall (combinational, same cycle).
//  ForwardAE: 10 if RegWriteM & WriteRegM==RsE; else 01 if RegWriteW & WriteRegW==RsE; else 00.
//    MEM wins over WB. ForwardBE identical on RtE.
//  ForwardAD = RegWriteM & WriteRegM==RsD; ForwardBD likewise on RtD.
//  MDU FSM, states IDLE/BUSY, counter cnt[CNT_W-1:0]:
//   MdIssue = (state==IDLE) & MdStartD & ~lwstall & ~brstall.
//   IDLE: MdIssue -> BUSY, cnt <= (MdIsDivD ? DIV_LAT : MULT_LAT)-1.
//   BUSY: cnt==0 -> IDLE; else cnt <= cnt-1.
//   MdBusy = (state==BUSY); high exactly LAT cycles after the issue edge.
//  Start/use pending while BUSY stalls.
//   The first IDLE cycle accepts it: start -> MdIssue, use -> no stall.
//   No back-to-back overlap.
//  Reset (Reset_n==0 at edge): state<=IDLE, cnt<=0.
//   While Reset_n==0, outputs forced: StallF=StallD=0, FlushE=1, Forward*=0, MdIssue=0.
//   Reset mid-BUSY aborts the op; MdBusy=0 from the next cycle.
//  Simultaneous lwstall and mdstall: single stall, MdIssue suppressed.
//   Issue retries on the cycle the load hazard clears.
// TESTING
//  lw $8 in EX (MemtoRegE=1,WriteRegE=8), RsD=8 -> StallF=StallD=FlushE=1 for 1 cycle, 0 the next.
//  RegWriteM=1,WriteRegM=5 and RegWriteW=1,WriteRegW=5, RsE=5 -> ForwardAE=10.
//  Same with WriteRegM=0 -> ForwardAE=01.
//  WriteRegE=0, RsD=0, MemtoRegE=1 -> no stall.
//  BranchD=1,RsD=3, RegWriteE=1,WriteRegE=3 -> stall 1 cycle.
//  Next cycle, with the producer now in MEM: no stall, ForwardAD=1.
//  div issued (MdStartD=1,MdIsDivD=1) -> MdIssue 1 cycle, MdBusy 10 cycles.
//  mflo in ID throughout -> stalled 10 cycles, released on cycle 11.
//  mult issued, Reset_n=0 at 2nd BUSY cycle -> MdBusy=0 next cycle, FlushE=1 during reset.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: register/control info from ID, EX, MEM and WB
// in one direction, and the stall, flush, forwarding and MDU controls back.
interface hazard_ctrl_if;
    logic [4:0] RsD, RtD, RsE, RtE;
    logic [4:0] WriteRegE, WriteRegM, WriteRegW;
    logic       BranchD, MdStartD, MdIsDivD, MdUseD;
    logic       RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
    logic       StallF, StallD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD;
    logic       MdIssue, MdBusy;

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               BranchD, MdStartD, MdIsDivD, MdUseD,
               RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW,
        output StallF, StallD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MdIssue, MdBusy
    );

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               BranchD, MdStartD, MdIsDivD, MdUseD,
               RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW,
        input  StallF, StallD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MdIssue, MdBusy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/scheduling controller for the 5-stage pipeline: load-use and branch stalls,
// EX/ID forwarding selects, and the busy sequencer for the shared multi-cycle MDU.
module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    hazard_ctrl_if.slave hz
);
    localparam logic [CNT_W-1:0] MULT_INIT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 1);

    typedef enum logic {IDLE, BUSY} mdState_t;

    mdState_t         stateReg;
    logic [CNT_W-1:0] cntReg;

    logic lwStall, brStall, mdStall, stall, mdIssue, mdBusy;

    // $0 is hard-wired zero, so a producer writing it never creates a dependency.
    function automatic logic hits(input logic [4:0] wr, input logic [4:0] src);
        return (wr != 5'd0) && (wr == src);
    endfunction

    always_comb begin
        mdBusy  = (stateReg == BUSY);
        lwStall = hz.RegWriteE & hz.MemtoRegE &
                  (hits(hz.WriteRegE, hz.RsD) | hits(hz.WriteRegE, hz.RtD));
        brStall = hz.BranchD &
                  ((hz.RegWriteE & (hits(hz.WriteRegE, hz.RsD) | hits(hz.WriteRegE, hz.RtD))) |
                   (hz.MemtoRegM & (hits(hz.WriteRegM, hz.RsD) | hits(hz.WriteRegM, hz.RtD))));
        mdStall = mdBusy & (hz.MdStartD | hz.MdUseD);
        stall   = lwStall | brStall | mdStall;
        mdIssue = Reset_n & (stateReg == IDLE) & hz.MdStartD & ~lwStall & ~brStall;
    end

    always_comb begin
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.FlushE    = 1'b1;
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        hz.ForwardAD = 1'b0;
        hz.ForwardBD = 1'b0;
        hz.MdIssue   = mdIssue;
        hz.MdBusy    = mdBusy;
        if (Reset_n) begin
            hz.StallF = stall;
            hz.StallD = stall;
            hz.FlushE = stall;
            // MEM holds the younger result, so it takes priority over WB.
            if (hz.RegWriteM && hits(hz.WriteRegM, hz.RsE))      hz.ForwardAE = 2'b10;
            else if (hz.RegWriteW && hits(hz.WriteRegW, hz.RsE)) hz.ForwardAE = 2'b01;
            if (hz.RegWriteM && hits(hz.WriteRegM, hz.RtE))      hz.ForwardBE = 2'b10;
            else if (hz.RegWriteW && hits(hz.WriteRegW, hz.RtE)) hz.ForwardBE = 2'b01;
            hz.ForwardAD = hz.RegWriteM & hits(hz.WriteRegM, hz.RsD);
            hz.ForwardBD = hz.RegWriteM & hits(hz.WriteRegM, hz.RtD);
        end
    end

    // Counter is loaded with LAT-1 so BUSY lasts exactly LAT cycles.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            stateReg <= IDLE;
            cntReg   <= '0;
        end else begin
            case (stateReg)
                IDLE: if (mdIssue) begin
                    stateReg <= BUSY;
                    cntReg   <= hz.MdIsDivD ? DIV_INIT : MULT_INIT;
                end
                BUSY: if (cntReg == '0) stateReg <= IDLE;
                      else              cntReg   <= cntReg - CNT_W'(1);
                default: stateReg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: stalls, forwarding, MDU sequencing, reset.
module tb_hazard_ctrl;
    logic Clk = 1'b0;
    logic Reset_n;
    int   checks = 0;
    int   failures = 0;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .hz      (hz)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearIn();
        hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
        hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
        hz.BranchD = 0; hz.MdStartD = 0; hz.MdIsDivD = 0; hz.MdUseD = 0;
        hz.RegWriteE = 0; hz.MemtoRegE = 0; hz.RegWriteM = 0; hz.MemtoRegM = 0;
        hz.RegWriteW = 0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chkStall(input string tag, input logic exp);
        chk({tag, "_StallF"}, {7'd0, hz.StallF}, {7'd0, exp});
        chk({tag, "_StallD"}, {7'd0, hz.StallD}, {7'd0, exp});
        chk({tag, "_FlushE"}, {7'd0, hz.FlushE}, {7'd0, exp});
    endtask

    initial begin
        // Reset with inputs that would otherwise forward/issue
        clearIn();
        Reset_n = 0;
        hz.RegWriteM = 1; hz.WriteRegM = 5; hz.RsE = 5; hz.MdStartD = 1;
        #1;
        chk("rst_FlushE", {7'd0, hz.FlushE}, 8'd1);
        chk("rst_StallF", {7'd0, hz.StallF}, 8'd0);
        chk("rst_FwdAE", {6'd0, hz.ForwardAE}, 8'd0);
        chk("rst_MdIssue", {7'd0, hz.MdIssue}, 8'd0);
        tick(); tick();
        chk("rst_MdBusy", {7'd0, hz.MdBusy}, 8'd0);
        $display("reset phase done checks=%0d", checks);

        Reset_n = 1; clearIn(); #1;
        chkStall("idle", 0);
        tick();

        // Load-use hazard then release
        hz.RegWriteE = 1; hz.MemtoRegE = 1; hz.WriteRegE = 8; hz.RsD = 8; #1;
        chkStall("lw", 1);
        tick();
        clearIn(); hz.RsD = 8; hz.RegWriteM = 1; hz.MemtoRegM = 1; hz.WriteRegM = 8; #1;
        chkStall("lw_next", 0);
        $display("load-use transaction done");
        tick();

        // EX forwarding priority
        clearIn();
        hz.RegWriteM = 1; hz.WriteRegM = 5; hz.RegWriteW = 1; hz.WriteRegW = 5;
        hz.RsE = 5; hz.RtE = 5; #1;
        chk("fwdAE_mem", {6'd0, hz.ForwardAE}, 8'd2);
        chk("fwdBE_mem", {6'd0, hz.ForwardBE}, 8'd2);
        hz.WriteRegM = 0; #1;
        chk("fwdAE_wb", {6'd0, hz.ForwardAE}, 8'd1);
        hz.RtE = 6; #1;
        chk("fwdBE_none", {6'd0, hz.ForwardBE}, 8'd0);
        hz.WriteRegW = 0; hz.RsE = 0; #1;
        chk("fwdAE_r0", {6'd0, hz.ForwardAE}, 8'd0);
        $display("forwarding transaction done");
        tick();

        // $0 never stalls
        clearIn(); hz.RegWriteE = 1; hz.MemtoRegE = 1; hz.WriteRegE = 0; hz.RsD = 0; #1;
        chkStall("lw_r0", 0);
        tick();

        // Branch dependent on ALU op in EX, then forwarded from MEM
        clearIn(); hz.BranchD = 1; hz.RsD = 3; hz.RegWriteE = 1; hz.WriteRegE = 3; #1;
        chkStall("br", 1);
        chk("br_FwdAD0", {7'd0, hz.ForwardAD}, 8'd0);
        tick();
        clearIn(); hz.BranchD = 1; hz.RsD = 3; hz.RegWriteM = 1; hz.WriteRegM = 3; #1;
        chkStall("br_next", 0);
        chk("br_FwdAD", {7'd0, hz.ForwardAD}, 8'd1);
        chk("br_FwdBD", {7'd0, hz.ForwardBD}, 8'd0);
        hz.RsD = 0; hz.RtD = 3; hz.MemtoRegM = 1; #1;
        chkStall("br_ldM", 1);
        chk("br_FwdBD1", {7'd0, hz.ForwardBD}, 8'd1);
        $display("branch transaction done");
        tick();

        // div issue, mflo waits 10 cycles
        clearIn(); hz.MdStartD = 1; hz.MdIsDivD = 1; #1;
        chk("div_issue", {7'd0, hz.MdIssue}, 8'd1);
        chkStall("div_issue", 0);
        tick();
        clearIn(); hz.MdUseD = 1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk($sformatf("div_busy%0d", i), {7'd0, hz.MdBusy}, 8'd1);
            chk($sformatf("div_stall%0d", i), {7'd0, hz.StallD}, 8'd1);
            tick();
        end
        #1;
        chk("div_done_busy", {7'd0, hz.MdBusy}, 8'd0);
        chkStall("div_release", 0);
        $display("div transaction done");
        tick();

        // mult followed by a held second mult: issues on first IDLE cycle
        clearIn(); hz.MdStartD = 1; #1;
        chk("mul1_issue", {7'd0, hz.MdIssue}, 8'd1);
        tick();
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("mul1_busy%0d", i), {7'd0, hz.MdBusy}, 8'd1);
            chk($sformatf("mul2_wait%0d", i), {7'd0, hz.MdIssue}, 8'd0);
            chk($sformatf("mul2_stall%0d", i), {7'd0, hz.StallF}, 8'd1);
            tick();
        end
        #1;
        chk("mul2_issue", {7'd0, hz.MdIssue}, 8'd1);
        chkStall("mul2_issue", 0);
        tick();
        hz.MdStartD = 0;
        repeat (5) tick();
        #1;
        chk("mul2_done", {7'd0, hz.MdBusy}, 8'd0);
        $display("back-to-back mult transaction done");
        tick();

        // Load hazard and MDU start together: issue deferred
        clearIn(); hz.MdStartD = 1; hz.RegWriteE = 1; hz.MemtoRegE = 1;
        hz.WriteRegE = 9; hz.RtD = 9; #1;
        chk("lwmd_issue", {7'd0, hz.MdIssue}, 8'd0);
        chkStall("lwmd", 1);
        tick();
        chk("lwmd_busy", {7'd0, hz.MdBusy}, 8'd0);
        hz.RegWriteE = 0; hz.MemtoRegE = 0; hz.WriteRegE = 0; #1;
        chk("lwmd_retry", {7'd0, hz.MdIssue}, 8'd1);
        tick();
        hz.MdStartD = 0; #1;
        chk("mulrst_busy1", {7'd0, hz.MdBusy}, 8'd1);
        tick();

        // Reset during 2nd BUSY cycle aborts the op
        Reset_n = 0; hz.MdUseD = 1; hz.RegWriteM = 1; hz.WriteRegM = 4; hz.RsD = 4; #1;
        chk("mulrst_busy2", {7'd0, hz.MdBusy}, 8'd1);
        chk("mulrst_FlushE", {7'd0, hz.FlushE}, 8'd1);
        chk("mulrst_StallF", {7'd0, hz.StallF}, 8'd0);
        chk("mulrst_FwdAD", {7'd0, hz.ForwardAD}, 8'd0);
        tick();
        chk("mulrst_abort", {7'd0, hz.MdBusy}, 8'd0);
        Reset_n = 1; clearIn(); #1;
        chkStall("post_rst", 0);
        $display("reset-abort transaction done");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
